// File: rtl/data_cache.sv
// data_cache: blocking direct-mapped write-back / write-allocate data cache
// with an internal fixed-latency backing word memory.
// Build option: define DCACHE_MEM_INIT_EN to preload backing word i with
// value i; otherwise the backing memory powers up as all zeros.
module data_cache #(
  parameter int unsigned LINES       = 8,
  parameter int unsigned LINE_WORDS  = 4,
  parameter int unsigned MEM_WORDS   = 256,
  parameter int unsigned MEM_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        r0w1,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic        rdy,
  output logic [31:0] dout
);

  localparam int unsigned OFF_W     = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W     = $clog2(LINES);
  localparam int unsigned TAG_W     = 32 - 2 - OFF_W - IDX_W;
  localparam int unsigned MEM_LINES = MEM_WORDS / LINE_WORDS;
  localparam int unsigned MEM_LW    = $clog2(MEM_LINES);
  localparam int unsigned CNT_W     = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITEBACK,
    S_ALLOCATE
  } state_e;

  typedef logic [LINE_WORDS-1:0][31:0]             line_t;
  typedef logic [MEM_LINES-1:0][LINE_WORDS-1:0][31:0] mem_t;

  // Power-on image of the backing memory (it is never cleared by reset).
  function automatic mem_t mem_image();
    mem_t m;
    for (int unsigned l = 0; l < MEM_LINES; l++) begin
      for (int unsigned w = 0; w < LINE_WORDS; w++) begin
`ifdef DCACHE_MEM_INIT_EN
        m[l][w] = 32'(l * LINE_WORDS + w);
`else
        m[l][w] = 32'h0;
`endif
      end
    end
    return m;
  endfunction

  // Lines are aligned in memory, so a whole line moves as one memory row.
  function automatic logic [MEM_LW-1:0] mem_row(input logic [TAG_W-1:0] t,
                                                input logic [IDX_W-1:0] i);
    return MEM_LW'({t, i});
  endfunction

  mem_t mem = mem_image();

  line_t              data_q [LINES];
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [LINES-1:0]   valid_q;
  logic [LINES-1:0]   dirty_q;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   miss_idx_q;
  logic [TAG_W-1:0]   miss_tag_q;

  logic [OFF_W-1:0]   a_off;
  logic [IDX_W-1:0]   a_idx;
  logic [TAG_W-1:0]   a_tag;
  logic               hit;
  logic               hit_wr;
  logic               miss_start;
  logic               wb_done;
  logic               fill_done;
  logic               unused_byte_bits;

  assign a_off            = addr[2 +: OFF_W];
  assign a_idx            = addr[2 + OFF_W +: IDX_W];
  assign a_tag            = addr[31 -: TAG_W];
  assign hit              = valid_q[a_idx] && (tag_q[a_idx] == a_tag);
  assign unused_byte_bits = ^addr[1:0];

  // State and transfer-cycle counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, processor handshake and transfer strobes.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rdy        = 1'b0;
    dout       = 32'h0;
    hit_wr     = 1'b0;
    miss_start = 1'b0;
    wb_done    = 1'b0;
    fill_done  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (en) begin
          if (hit) begin
            rdy = 1'b1;
            if (r0w1) hit_wr = 1'b1;
            else      dout   = data_q[a_idx][a_off];
          end else begin
            miss_start = 1'b1;
            cnt_d      = '0;
            state_d    = dirty_q[a_idx] ? S_WRITEBACK : S_ALLOCATE;
          end
        end
      end
      S_WRITEBACK: begin
        if (cnt_q == CNT_LAST) begin
          wb_done = 1'b1;
          cnt_d   = '0;
          state_d = S_ALLOCATE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_ALLOCATE: begin
        if (cnt_q == CNT_LAST) begin
          fill_done = 1'b1;
          cnt_d     = '0;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Line status and the captured miss address (fill runs even if en drops).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q    <= '0;
      dirty_q    <= '0;
      miss_idx_q <= '0;
      miss_tag_q <= '0;
    end else begin
      if (miss_start) begin
        miss_idx_q <= a_idx;
        miss_tag_q <= a_tag;
      end
      if (fill_done) begin
        valid_q[miss_idx_q] <= 1'b1;
        dirty_q[miss_idx_q] <= 1'b0;
      end
      if (hit_wr) dirty_q[a_idx] <= 1'b1;
    end
  end

  // Line data, tags and backing memory; strobes are idle while in reset.
  always_ff @(posedge clk) begin
    if (wb_done) begin
      mem[mem_row(tag_q[miss_idx_q], miss_idx_q)] <= data_q[miss_idx_q];
    end
    if (fill_done) begin
      data_q[miss_idx_q] <= mem[mem_row(miss_tag_q, miss_idx_q)];
      tag_q[miss_idx_q]  <= miss_tag_q;
    end
    if (hit_wr) data_q[a_idx][a_off] <= din;
  end

endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: directed scenarios plus random traffic against an
// operation-level cache/memory reference model.
module tb_data_cache;

  localparam int unsigned LAT = 4;

  logic        clk  = 1'b0;
  logic        rst  = 1'b0;
  logic        en   = 1'b0;
  logic        r0w1 = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] din  = 32'h0;
  logic        rdy;
  logic [31:0] dout;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: backing memory plus per-line state, updated per operation.
  logic [31:0] m_mem   [256];
  bit          m_valid [8];
  bit          m_dirty [8];
  logic [24:0] m_tag   [8];
  logic [31:0] m_data  [8][4];

  data_cache #(
    .LINES      (8),
    .LINE_WORDS (4),
    .MEM_WORDS  (256),
    .MEM_LATENCY(LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .r0w1(r0w1),
    .addr(addr),
    .din (din),
    .rdy (rdy),
    .dout(dout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endtask

  // Apply one access to the model; returns expected cycles-to-rdy and read data.
  task automatic ref_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                            output int lat, output logic [31:0] rd);
    int          i;
    int          o;
    int          base;
    logic [24:0] t;
    logic [31:0] vaddr;
    i = int'(a[6:4]);
    o = int'(a[3:2]);
    t = a[31:7];
    if (m_valid[i] && m_tag[i] == t) begin
      lat = 0;
    end else begin
      if (m_valid[i] && m_dirty[i]) begin
        lat   = 2 * LAT + 1;
        vaddr = {m_tag[i], 3'(i), 4'h0};
        base  = int'((vaddr >> 2) % 256);
        for (int k = 0; k < 4; k++) m_mem[base + k] = m_data[i][k];
      end else begin
        lat = LAT + 1;
      end
      base = int'((a >> 2) % 256);
      base = base - (base % 4);
      for (int k = 0; k < 4; k++) m_data[i][k] = m_mem[base + k];
      m_valid[i] = 1'b1;
      m_dirty[i] = 1'b0;
      m_tag[i]   = t;
    end
    if (w) begin
      m_data[i][o] = d;
      m_dirty[i]   = 1'b1;
      rd           = 32'h0;
    end else begin
      rd = m_data[i][o];
    end
  endtask

  // Issue one request (called just after a rising edge); returns after the commit edge.
  task automatic do_op(input string tg, input logic w, input logic [31:0] a, input logic [31:0] d);
    int          exp_lat;
    int          lat;
    logic [31:0] exp_rd;
    bit          done;
    bit          tmo;
    ref_access(w, a, d, exp_lat, exp_rd);
    en   = 1'b1;
    r0w1 = w;
    addr = a;
    din  = d;
    lat  = 0;
    done = 1'b0;
    tmo  = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (rdy) begin
        done = 1'b1;
      end else begin
        lat++;
        if (lat > 2 * LAT + 4) begin
          tmo  = 1'b1;
          done = 1'b1;
        end else begin
          @(posedge clk);
          #1;
        end
      end
    end
    check({tg, "_lat"}, 32'(lat), 32'(exp_lat));
    if (!tmo) check({tg, "_dout"}, dout, exp_rd);
    @(posedge clk);
    #1;
  endtask

  // Hold en low for n cycles, optionally checking the outputs stay quiet.
  task automatic idle(input int n, input bit chk);
    en = 1'b0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (chk) begin
        check("idle_rdy", 32'(rdy), 32'h0);
        check("idle_dout", dout, 32'h0);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [31:0] a;
    int          lat_ign;
    logic [31:0] rd_ign;

    for (int i = 0; i < 256; i++) begin
`ifdef DCACHE_MEM_INIT_EN
      m_mem[i] = 32'(i);
`else
      m_mem[i] = 32'h0;
`endif
    end
    model_reset();

    // Reset state, including a request presented while held in reset.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rdy", 32'(rdy), 32'h0);
    check("rst_dout", dout, 32'h0);
    en   = 1'b1;
    addr = 32'h4;
    #1;
    check("rst_en_rdy", 32'(rdy), 32'h0);
    en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Clean miss then hit.
    do_op("t1_miss", 1'b0, 32'h0000_0004, 32'h0);
    do_op("t1_hit", 1'b0, 32'h0000_0004, 32'h0);
    // Write hit then read back.
    do_op("t2_wr", 1'b1, 32'h0000_0004, 32'h5A5A_5A5A);
    do_op("t2_rd", 1'b0, 32'h0000_0004, 32'h0);
    // Dirty conflict miss, then clean miss that sees the written-back word.
    do_op("t3_dirty", 1'b0, 32'h0000_0084, 32'h0);
    do_op("t3_clean", 1'b0, 32'h0000_0004, 32'h0);
    // Write-allocate, then hits in the same line (byte bits ignored).
    do_op("t4_wmiss", 1'b1, 32'h0000_0110, 32'hDEAD_BEEF);
    do_op("t4_rd110", 1'b0, 32'h0000_0110, 32'h0);
    do_op("t4_rd114", 1'b0, 32'h0000_0114, 32'h0);
    do_op("t4_rd117", 1'b0, 32'h0000_0117, 32'h0);

    // Reset during ALLOCATE aborts the fill.
    idle(1, 1'b0);
    en   = 1'b1;
    r0w1 = 1'b0;
    addr = 32'h0000_0230;
    repeat (3) @(negedge clk);
    check("t5_pre_rdy", 32'(rdy), 32'h0);
    rst = 1'b0;
    en  = 1'b0;
    #1;
    check("t5_rst_rdy", 32'(rdy), 32'h0);
    check("t5_rst_dout", dout, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    do_op("t5_refill", 1'b0, 32'h0000_0230, 32'h0);
    do_op("t5_rd04", 1'b0, 32'h0000_0004, 32'h0);

    // en low in IDLE with a cached address on the bus.
    addr = 32'h0000_0230;
    idle(10, 1'b1);

    // en dropped mid-miss: fill still completes and the line then hits.
    ref_access(1'b0, 32'h0000_0350, 32'h0, lat_ign, rd_ign);
    en   = 1'b1;
    r0w1 = 1'b0;
    addr = 32'h0000_0350;
    repeat (2) @(negedge clk);
    en = 1'b0;
    repeat (2 * LAT + 2) @(posedge clk);
    #1;
    do_op("drop_hit", 1'b0, 32'h0000_0350, 32'h0);

    // Random traffic: small word window for conflicts, high bits for tag aliasing.
    for (int n = 0; n < 400; n++) begin
      a = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) a = a | (32'h0000_0400 << $urandom_range(0, 21));
      do_op("rnd", 1'($urandom_range(0, 1)), a, $urandom);
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish first");
    $fatal(1, "watchdog expired");
  end

endmodule
